// File: rtl/synth_pkg.sv
// Shared types and helpers for the voice allocator slice.
package synth_pkg;

    // Allocator sequencing: accept, walk the voices, apply, optional envelope re-arm gap
    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        COMMIT,
        GAP
    } alloc_state_e;

    // Index width for a count of n items, never narrower than one bit
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/voice_age_tracker.sv
// Per-voice saturating age counters; reports the oldest voice (lowest index on ties).
module voice_age_tracker
    import synth_pkg::*;
#(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned AGE_W      = 4,
    parameter int unsigned IDX_W      = idx_width(NUM_VOICES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bump,
    input  logic [IDX_W-1:0] clear_idx,
    output logic [IDX_W-1:0] oldest_idx
);

    logic [AGE_W-1:0] age [NUM_VOICES];
    logic [AGE_W-1:0] best;

    // On a bump the chosen voice restarts at zero and every other voice ages by one, saturating
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_VOICES; i++) begin
                age[i] <= '0;
            end
        end else if (bump) begin
            for (int unsigned i = 0; i < NUM_VOICES; i++) begin
                if (IDX_W'(i) == clear_idx) begin
                    age[i] <= '0;
                end else if (age[i] != '1) begin
                    age[i] <= age[i] + 1'b1;
                end
            end
        end
    end

    // Strict greater-than while walking upward keeps the lowest index on ties
    always_comb begin
        oldest_idx = '0;
        best       = age[0];
        for (int unsigned i = 1; i < NUM_VOICES; i++) begin
            if (age[i] > best) begin
                best       = age[i];
                oldest_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: note events in, per-voice gate/note/amp out.
// Policy: retrigger matching voice, else lowest free voice, else steal the oldest.
module voice_allocator
    import synth_pkg::*;
#(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned NOTE_W     = 8,
    parameter int unsigned AMP_W      = 16,
    parameter int unsigned AGE_W      = 4,
    parameter int unsigned GAP_CYCLES = 16
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         ev_valid,
    output logic                         ev_ready,
    input  logic                         ev_note_on,
    input  logic [NOTE_W-1:0]            ev_note,
    input  logic [AMP_W-1:0]             ev_amp,
    input  logic                         all_off,
    output logic [NUM_VOICES-1:0]        key_on,
    output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
    output logic [NUM_VOICES*AMP_W-1:0]  voice_amp,
    output logic                         steal
);

    localparam int unsigned IDX_W = idx_width(NUM_VOICES);
    localparam int unsigned GAP_W = idx_width(GAP_CYCLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    typedef struct packed {
        logic              note_on;
        logic [NOTE_W-1:0] note;
        logic [AMP_W-1:0]  amp;
    } note_event_t;

    alloc_state_e     state;
    note_event_t      ev_q;
    logic [IDX_W-1:0] scan_idx;
    logic [IDX_W-1:0] match_idx;
    logic [IDX_W-1:0] free_idx;
    logic [IDX_W-1:0] target_idx;
    logic [IDX_W-1:0] oldest_idx;
    logic [IDX_W-1:0] commit_tgt;
    logic             match_found;
    logic             free_found;
    logic             age_bump;
    logic [GAP_W-1:0] gap_cnt;
    logic [NOTE_W-1:0] note_r [NUM_VOICES];
    logic [AMP_W-1:0]  amp_r  [NUM_VOICES];

    // Ages are static while scanning, so the tracker's live oldest_idx is used directly at commit
    voice_age_tracker #(
        .NUM_VOICES (NUM_VOICES),
        .AGE_W      (AGE_W),
        .IDX_W      (IDX_W)
    ) u_age (
        .clk        (Clk),
        .reset      (Reset),
        .bump       (age_bump),
        .clear_idx  (commit_tgt),
        .oldest_idx (oldest_idx)
    );

    // Target selection priority and the age update strobe for note-on commits
    always_comb begin
        commit_tgt = match_found ? match_idx : (free_found ? free_idx : oldest_idx);
        age_bump   = !Reset && !all_off && (state == COMMIT) && ev_q.note_on;
    end

    // Flatten the per-voice registers onto the packed output buses
    always_comb begin
        voice_note = '0;
        voice_amp  = '0;
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            voice_note[i*NOTE_W +: NOTE_W] = note_r[i];
            voice_amp[i*AMP_W +: AMP_W]    = amp_r[i];
        end
    end

    // Allocator FSM with all externally visible outputs registered
    always_ff @(posedge Clk) begin
        steal <= 1'b0;
        if (Reset) begin
            state       <= IDLE;
            ev_ready    <= 1'b0;
            key_on      <= '0;
            ev_q        <= '0;
            scan_idx    <= '0;
            match_idx   <= '0;
            free_idx    <= '0;
            target_idx  <= '0;
            match_found <= 1'b0;
            free_found  <= 1'b0;
            gap_cnt     <= '0;
            for (int unsigned i = 0; i < NUM_VOICES; i++) begin
                note_r[i] <= '0;
                amp_r[i]  <= '0;
            end
        end else if (all_off) begin
            key_on   <= '0;
            state    <= IDLE;
            ev_ready <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ev_valid && ev_ready) begin
                        ev_q        <= '{note_on: ev_note_on, note: ev_note, amp: ev_amp};
                        scan_idx    <= '0;
                        match_found <= 1'b0;
                        free_found  <= 1'b0;
                        ev_ready    <= 1'b0;
                        state       <= SCAN;
                    end else begin
                        ev_ready <= 1'b1;
                    end
                end
                SCAN: begin
                    if (!match_found && key_on[scan_idx] && (note_r[scan_idx] == ev_q.note)) begin
                        match_found <= 1'b1;
                        match_idx   <= scan_idx;
                    end
                    if (!free_found && !key_on[scan_idx]) begin
                        free_found <= 1'b1;
                        free_idx   <= scan_idx;
                    end
                    if (scan_idx == LAST_IDX) begin
                        state <= COMMIT;
                    end else begin
                        scan_idx <= scan_idx + 1'b1;
                    end
                end
                COMMIT: begin
                    if (!ev_q.note_on) begin
                        if (match_found) begin
                            key_on[match_idx] <= 1'b0;
                        end
                        state <= IDLE;
                    end else begin
                        note_r[commit_tgt] <= ev_q.note;
                        amp_r[commit_tgt]  <= ev_q.amp;
                        target_idx         <= commit_tgt;
                        if (!match_found && free_found) begin
                            key_on[commit_tgt] <= 1'b1;
                            state              <= IDLE;
                        end else begin
                            key_on[commit_tgt] <= 1'b0;
                            gap_cnt            <= '0;
                            steal              <= !match_found;
                            state              <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        key_on[target_idx] <= 1'b1;
                        state              <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: table of events with scoreboarded expectations
// plus hand-written sequences for all_off and reset corner cases.
module tb_voice_allocator;

    localparam int unsigned NV  = 4;
    localparam int unsigned NW  = 8;
    localparam int unsigned AW  = 16;
    localparam int unsigned GAP = 16;

    logic           Clk = 1'b0;
    logic           Reset;
    logic           ev_valid;
    logic           ev_ready;
    logic           ev_note_on;
    logic [NW-1:0]  ev_note;
    logic [AW-1:0]  ev_amp;
    logic           all_off;
    logic [NV-1:0]  key_on;
    logic [NV*NW-1:0] voice_note;
    logic [NV*AW-1:0] voice_amp;
    logic           steal;

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    voice_allocator #(
        .NUM_VOICES (NV),
        .NOTE_W     (NW),
        .AMP_W      (AW),
        .AGE_W      (4),
        .GAP_CYCLES (GAP)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_note_on (ev_note_on),
        .ev_note    (ev_note),
        .ev_amp     (ev_amp),
        .all_off    (all_off),
        .key_on     (key_on),
        .voice_note (voice_note),
        .voice_amp  (voice_amp),
        .steal      (steal)
    );

    typedef struct {
        bit          on;
        logic [7:0]  note;
        logic [15:0] amp;
        logic [3:0]  key_commit;
        logic [3:0]  key_final;
        bit          steal;
        bit          gap;
        int unsigned tgt;
        logic [7:0]  exp_note;
        logic [15:0] exp_amp;
    } vec_t;

    vec_t vecs [13];
    vec_t sb [$];

    function automatic logic [NW-1:0] vnote(input int unsigned i);
        return voice_note[i*NW +: NW];
    endfunction

    function automatic logic [AW-1:0] vamp(input int unsigned i);
        return voice_amp[i*AW +: AW];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one event; returns at the negedge following the accepting posedge
    task automatic send(input bit on, input logic [NW-1:0] note, input logic [AW-1:0] amp);
        int unsigned waited;
        @(negedge Clk);
        ev_valid   = 1'b1;
        ev_note_on = on;
        ev_note    = note;
        ev_amp     = amp;
        waited     = 0;
        while (!ev_ready) begin
            @(negedge Clk);
            waited++;
            if (waited > 100) begin
                total++;
                bad++;
                $display("FAIL ready_timeout: got ev_ready=0 expected 1 within 100 cycles");
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
        end
        @(posedge Clk);
        @(negedge Clk);
        ev_valid   = 1'b0;
        ev_note_on = 1'b0;
        ev_note    = '0;
        ev_amp     = '0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        vec_t e;
        logic [NV-1:0] prev;
        int unsigned seen70;

        vecs[0]  = '{1'b1, 8'd60, 16'h4000, 4'b0001, 4'b0001, 1'b0, 1'b0, 0, 8'd60, 16'h4000};
        vecs[1]  = '{1'b1, 8'd62, 16'h1111, 4'b0011, 4'b0011, 1'b0, 1'b0, 1, 8'd62, 16'h1111};
        vecs[2]  = '{1'b1, 8'd64, 16'h2222, 4'b0111, 4'b0111, 1'b0, 1'b0, 2, 8'd64, 16'h2222};
        vecs[3]  = '{1'b1, 8'd65, 16'h3333, 4'b1111, 4'b1111, 1'b0, 1'b0, 3, 8'd65, 16'h3333};
        vecs[4]  = '{1'b1, 8'd67, 16'h5555, 4'b1110, 4'b1111, 1'b1, 1'b1, 0, 8'd67, 16'h5555};
        vecs[5]  = '{1'b1, 8'd62, 16'h6666, 4'b1101, 4'b1111, 1'b0, 1'b1, 1, 8'd62, 16'h6666};
        vecs[6]  = '{1'b0, 8'd64, 16'h0000, 4'b1011, 4'b1011, 1'b0, 1'b0, 2, 8'd64, 16'h2222};
        vecs[7]  = '{1'b0, 8'd64, 16'h0000, 4'b1011, 4'b1011, 1'b0, 1'b0, 2, 8'd64, 16'h2222};
        vecs[8]  = '{1'b1, 8'd70, 16'h0000, 4'b1111, 4'b1111, 1'b0, 1'b0, 2, 8'd70, 16'h0000};
        vecs[9]  = '{1'b1, 8'd72, 16'h7777, 4'b0111, 4'b1111, 1'b1, 1'b1, 3, 8'd72, 16'h7777};
        vecs[10] = '{1'b0, 8'd67, 16'h0000, 4'b1110, 4'b1110, 1'b0, 1'b0, 0, 8'd67, 16'h5555};
        vecs[11] = '{1'b0, 8'd99, 16'h0000, 4'b1110, 4'b1110, 1'b0, 1'b0, 0, 8'd67, 16'h5555};
        vecs[12] = '{1'b1, 8'd60, 16'h1234, 4'b1111, 4'b1111, 1'b0, 1'b0, 0, 8'd60, 16'h1234};

        Reset      = 1'b1;
        ev_valid   = 1'b0;
        ev_note_on = 1'b0;
        ev_note    = '0;
        ev_amp     = '0;
        all_off    = 1'b0;

        // Reset values, then ev_ready one cycle later
        @(negedge Clk);
        check("rst_key_on", key_on, 4'b0000);
        check("rst_note", voice_note, '0);
        check("rst_amp", voice_amp, '0);
        check("rst_steal", steal, 1'b0);
        check("rst_ready", ev_ready, 1'b0);
        Reset = 1'b0;
        @(negedge Clk);
        check("rst_ready_next", ev_ready, 1'b1);

        // Table-driven event stream
        for (int i = 0; i < 13; i++) begin
            v    = vecs[i];
            prev = key_on;
            send(v.on, v.note, v.amp);
            sb.push_back(v);
            repeat (4) @(negedge Clk);
            check($sformatf("v%0d_latency_hold", i), key_on, prev);
            @(negedge Clk);
            e = sb.pop_front();
            check($sformatf("v%0d_key_commit", i), key_on, e.key_commit);
            check($sformatf("v%0d_steal", i), steal, e.steal);
            check($sformatf("v%0d_note", i), vnote(e.tgt), e.exp_note);
            check($sformatf("v%0d_amp", i), vamp(e.tgt), e.exp_amp);
            check($sformatf("v%0d_ready_busy", i), ev_ready, 1'b0);
            if (e.gap) begin
                @(negedge Clk);
                check($sformatf("v%0d_steal_pulse_end", i), steal, 1'b0);
                repeat (GAP - 2) @(negedge Clk);
                check($sformatf("v%0d_gap_hold", i), key_on, e.key_commit);
                @(negedge Clk);
                check($sformatf("v%0d_key_final", i), key_on, e.key_final);
                check($sformatf("v%0d_ready_gap", i), ev_ready, 1'b0);
            end
            @(negedge Clk);
            check($sformatf("v%0d_ready_back", i), ev_ready, 1'b1);
            check($sformatf("v%0d_key_settled", i), key_on, e.key_final);
        end

        // Reset during GAP while a new event is already waiting
        send(1'b1, 8'd62, 16'h0101);
        repeat (8) @(negedge Clk);
        Reset      = 1'b1;
        ev_valid   = 1'b1;
        ev_note_on = 1'b1;
        ev_note    = 8'd50;
        ev_amp     = 16'h0ABC;
        @(negedge Clk);
        check("gaprst_key_on", key_on, 4'b0000);
        check("gaprst_note", voice_note, '0);
        check("gaprst_amp", voice_amp, '0);
        check("gaprst_steal", steal, 1'b0);
        check("gaprst_ready", ev_ready, 1'b0);
        Reset = 1'b0;
        @(negedge Clk);
        check("gaprst_ready_next", ev_ready, 1'b1);
        @(posedge Clk);
        @(negedge Clk);
        ev_valid = 1'b0;
        check("gaprst_accepted", ev_ready, 1'b0);
        repeat (5) @(negedge Clk);
        check("gaprst_key_commit", key_on, 4'b0001);
        check("gaprst_note0", vnote(0), 8'd50);
        check("gaprst_amp0", vamp(0), 16'h0ABC);
        @(negedge Clk);

        // all_off during SCAN drops the in-flight note-on
        send(1'b1, 8'd70, 16'h0777);
        @(negedge Clk);
        all_off = 1'b1;
        @(negedge Clk);
        all_off = 1'b0;
        check("alloff_key_on", key_on, 4'b0000);
        check("alloff_ready", ev_ready, 1'b0);
        repeat (10) @(negedge Clk);
        check("alloff_key_stays", key_on, 4'b0000);
        check("alloff_ready_back", ev_ready, 1'b1);
        check("alloff_note_held", vnote(0), 8'd50);
        check("alloff_amp_held", vamp(0), 16'h0ABC);
        seen70 = 0;
        for (int unsigned i = 0; i < NV; i++) begin
            if (vnote(i) == 8'd70) seen70++;
        end
        check("alloff_no_70", seen70, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
